timer_cnt_gen: RTL and testbench

- Count-signal generator sitting directly upstream of the timer core (Timer); drives its cnt_sig input.
- Contains three parts:
  - A machine-cycle prescaler.
  - Synchronisers for the external Tx and INTx pins.
  - 8051 run/gate/C-T qualification.
- Emits a one-clock increment pulse per qualified machine cycle (timer mode) or per qualified falling edge of Tx (counter mode).
- One instance per timer (T0, T1).

---
 rtl/timer_cnt_gen.sv | 77 +++++++
 tb/tb_timer_cnt_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/timer_cnt_gen.sv
// Count-signal generator for an 8051-style timer: prescales the clock into machine
// cycles, synchronises Tx/INTx, and emits one increment pulse per qualified event.
module timer_cnt_gen #(
  parameter int CLK_PER_MC  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tr,
  input  logic gate,
  input  logic ct_sel,
  input  logic int_n_pin,
  input  logic t_pin,
  output logic mc_tick,
  output logic run,
  output logic cnt_sig
);

  localparam int PW = (CLK_PER_MC > 1) ? $clog2(CLK_PER_MC) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_MC - 1);

  logic [PW-1:0]          r_presc;
  logic                   r_mc_tick;
  logic                   r_run;
  logic                   r_cnt_sig;
  logic                   r_t_samp;
  logic [SYNC_STAGES-1:0] r_t_sync;
  logic [SYNC_STAGES-1:0] r_int_sync;
  logic                   w_t_sync;
  logic                   w_int_sync;
  logic                   w_fall;

  assign w_t_sync   = r_t_sync[SYNC_STAGES-1];
  assign w_int_sync = r_int_sync[SYNC_STAGES-1];
  // t_samp holds Tx as seen at the previous tick, so a fall spans one machine cycle.
  assign w_fall     = r_mc_tick & r_t_samp & ~w_t_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_mc_tick <= 1'b0;
    end else begin
      r_mc_tick <= (r_presc == LAST);
      if (r_presc == LAST) r_presc <= '0;
      else                 r_presc <= r_presc + 1'b1;
    end
  end

  // Pins idle high, so the chains reset to 1 and no edge is seen on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t_sync   <= '1;
      r_int_sync <= '1;
      r_t_samp   <= 1'b1;
    end else begin
      r_t_sync   <= {r_t_sync[SYNC_STAGES-2:0], t_pin};
      r_int_sync <= {r_int_sync[SYNC_STAGES-2:0], int_n_pin};
      if (r_mc_tick) r_t_samp <= w_t_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_cnt_sig <= 1'b0;
    end else begin
      r_run <= tr & (~gate | w_int_sync);
      if (ct_sel) r_cnt_sig <= w_fall & r_run;
      else        r_cnt_sig <= r_mc_tick & r_run;
    end
  end

  assign mc_tick = r_mc_tick;
  assign run     = r_run;
  assign cnt_sig = r_cnt_sig;

endmodule

// File: tb/tb_timer_cnt_gen.sv
// Directed bench for timer_cnt_gen: edge-indexed reference model checked every cycle,
// plus literal pulse/tick counts for each scenario.
module tb_timer_cnt_gen;

  localparam int N    = 12;
  localparam int SYNC = 2;
  localparam int HMAX = 8192;

  logic clk, rst, tr, gate, ct_sel, int_n_pin, t_pin;
  logic mc_tick, run, cnt_sig;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cnt    = 0;
  int n_tick   = 0;

  // model: pin samples indexed by clock edge number since reset release
  logic t_h [HMAX];
  logic i_h [HMAX];
  int   m_e;
  logic m_tick, m_run, m_cnt, m_last_seen;
  logic prev_tick, prev_run, seen;

  timer_cnt_gen #(.CLK_PER_MC(N), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .tr(tr), .gate(gate), .ct_sel(ct_sel),
    .int_n_pin(int_n_pin), .t_pin(t_pin),
    .mc_tick(mc_tick), .run(run), .cnt_sig(cnt_sig)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic hist_t(int idx);
    return (idx < 1) ? 1'b1 : t_h[idx];
  endfunction

  function automatic logic hist_i(int idx);
    return (idx < 1) ? 1'b1 : i_h[idx];
  endfunction

  task automatic check_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model + per-cycle compare
  always @(posedge clk) begin
    if (rst) begin
      m_e = 0; m_tick = 0; m_run = 0; m_cnt = 0; m_last_seen = 1;
    end else begin
      prev_tick = m_tick;
      prev_run  = m_run;
      m_e++;
      if (m_e < HMAX) begin
        t_h[m_e] = t_pin;
        i_h[m_e] = int_n_pin;
      end
      m_tick = ((m_e % N) == 0);
      m_run  = tr & (~gate | hist_i(m_e - SYNC));
      m_cnt  = 0;
      if (prev_tick) begin
        seen  = hist_t(m_e - SYNC);
        m_cnt = prev_run & (ct_sel ? (m_last_seen & ~seen) : 1'b1);
        m_last_seen = seen;
      end
    end
    #1;
    check_bit("mc_tick", mc_tick, m_tick);
    check_bit("run", run, m_run);
    check_bit("cnt_sig", cnt_sig, m_cnt);
    if (cnt_sig) n_cnt++;
    if (mc_tick) n_tick++;
  end

  initial begin
    rst = 1; tr = 1; gate = 0; ct_sel = 0; int_n_pin = 1; t_pin = 1;
    clks(3);

    // 1: timer mode, 100 machine cycles
    rst = 0; n_cnt = 0; n_tick = 0;
    clks(11);
    check_bit("first_tick_pre", mc_tick, 1'b0);
    clks(1);
    check_bit("first_tick", mc_tick, 1'b1);
    clks(1189);
    check_int("s1_pulses", n_cnt, 100);
    check_int("s1_ticks", n_tick, 100);

    // 2: stopped for 50 machine cycles, then restart
    tr = 0; n_cnt = 0; n_tick = 0;
    clks(600);
    check_int("s2_stopped_pulses", n_cnt, 0);
    check_int("s2_stopped_ticks", n_tick, 50);
    tr = 1; n_cnt = 0;
    clks(120);
    check_int("s2_resumed_pulses", n_cnt, 10);

    // 3: gated by INTx low, then released
    gate = 1; int_n_pin = 0; n_cnt = 0;
    clks(240);
    check_int("s3_gated_pulses", n_cnt, 0);
    int_n_pin = 1; n_cnt = 0;
    clks(2);
    check_bit("s3_run_lat2", run, 1'b0);
    clks(1);
    check_bit("s3_run_lat3", run, 1'b1);
    clks(24);
    check_int("s3_resumed_pulses", n_cnt, 2);
    gate = 0;

    // 4: counter mode, fresh phase after reset
    rst = 1;
    clks(2);
    rst = 0; ct_sel = 1; n_cnt = 0;
    for (int p = 0; p < 10; p++) begin
      t_pin = 1; clks(24);
      t_pin = 0; clks(24);
    end
    check_int("s4_square_pulses", n_cnt, 10);
    t_pin = 1; clks(15);
    t_pin = 0; n_cnt = 0; clks(5);
    t_pin = 1; clks(40);
    check_int("s4_glitch_pulses", n_cnt, 0);

    // 5: async reset with prescaler at 7
    clks(7);
    #2 rst = 1;
    #1;
    check_bit("s5_async_tick", mc_tick, 1'b0);
    check_bit("s5_async_run", run, 1'b0);
    check_bit("s5_async_cnt", cnt_sig, 1'b0);
    clks(3);
    rst = 0; n_cnt = 0;
    clks(11);
    check_bit("s5_tick_pre", mc_tick, 1'b0);
    clks(1);
    check_bit("s5_tick", mc_tick, 1'b1);
    check_int("s5_stray_pulses", n_cnt, 0);

    // 6: switch to counter mode with Tx held low
    ct_sel = 0; t_pin = 0;
    clks(30);
    ct_sel = 1; n_cnt = 0;
    clks(48);
    check_int("s6_held_low_pulses", n_cnt, 0);
    t_pin = 1; n_cnt = 0;
    clks(24);
    t_pin = 0;
    clks(36);
    check_int("s6_fall_pulses", n_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
